// File: rtl/seq_alu.sv
// seq_alu: registered EX-stage ALU with iterative mul/div writing a HI/LO pair
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUctrl,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shiftAmount,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
    logic [1:0] state_q, state_d;
    logic [SHW:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d, quo_q, quo_d, result_q, result_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH:0] rem_q, rem_d, sum, shifted;
    logic [WIDTH+1:0] trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] alu_res, abs_a, abs_b, q_fix, r_fix;
    logic div_q, div_d, pneg_q, pneg_d, rneg_q, rneg_d;
    logic zero_q, zero_d, busy_q, busy_d, done_q, done_d;
    logic is_md, sa, sb;
    assign is_md = ALUctrl inside {4'b1010, 4'b1011, 4'b1100, 4'b1101};
    assign sa = ALUctrl[0] & input1[WIDTH-1];
    assign sb = ALUctrl[0] & input2[WIDTH-1];
    assign abs_a = sa ? -input1 : input1;
    assign abs_b = sb ? -input2 : input2;
    always_comb begin
        case (ALUctrl)
            4'b0000: alu_res = input1 & input2;
            4'b0001: alu_res = input1 | input2;
            4'b0010: alu_res = input1 + input2;
            4'b0011: alu_res = input1 ^ input2;
            4'b0100: alu_res = input2 << shiftAmount;
            4'b0101: alu_res = input2 >> shiftAmount;
            4'b1000: alu_res = $signed(input2) >>> shiftAmount;
            4'b0110: alu_res = input1 - input2;
            4'b0111: alu_res = WIDTH'($signed(input1) < $signed(input2));
            4'b1001: alu_res = WIDTH'(input1 < input2);
            4'b1110: alu_res = hi_q;
            4'b1111: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end
    // multiply: right-shifting {rem, quo} accumulator; divide: restoring step on {rem, quo}
    assign sum = rem_q + (quo_q[0] ? {1'b0, m_q} : '0);
    assign shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    assign trial = {1'b0, shifted} - {2'b00, m_q};
    assign prod = {rem_q[WIDTH-1:0], quo_q};
    assign prod_fix = pneg_q ? -prod : prod;
    assign q_fix = pneg_q ? -quo_q : quo_q;
    assign r_fix = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        m_d = m_q;
        rem_d = rem_q;
        quo_d = quo_q;
        div_d = div_q;
        pneg_d = pneg_q;
        rneg_d = rneg_q;
        result_d = result_q;
        zero_d = zero_q;
        busy_d = busy_q;
        done_d = 1'b0;
        hi_d = hi_q;
        lo_d = lo_q;
        case (state_q)
            IDLE: begin
                if (start && is_md) begin
                    state_d = RUN;
                    cnt_d = CNT_INIT;
                    busy_d = 1'b1;
                    div_d = ALUctrl[2];
                    m_d = ALUctrl[2] ? abs_b : abs_a;
                    quo_d = ALUctrl[2] ? abs_a : abs_b;
                    rem_d = '0;
                    // a zero divisor leaves the all-ones quotient unsigned
                    pneg_d = (sa ^ sb) & (input2 != '0);
                    rneg_d = sa;
                end else if (start) begin
                    result_d = alu_res;
                    zero_d = alu_res == '0;
                    done_d = 1'b1;
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                state_d = cnt_q == CNT_ONE ? FIX : RUN;
                if (div_q) begin
                    rem_d = trial[WIDTH+1] ? shifted : trial[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
                end else begin
                    rem_d = {1'b0, sum[WIDTH:1]};
                    quo_d = {sum[0], quo_q[WIDTH-1:1]};
                end
            end
            FIX: begin
                hi_d = div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo_d = div_q ? q_fix : prod_fix[WIDTH-1:0];
                result_d = lo_d;
                zero_d = lo_d == '0;
                done_d = 1'b1;
                busy_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            m_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            div_q <= 1'b0;
            pneg_q <= 1'b0;
            rneg_q <= 1'b0;
            result_q <= '0;
            zero_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            m_q <= m_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            div_q <= div_d;
            pneg_q <= pneg_d;
            rneg_q <= rneg_d;
            result_q <= result_d;
            zero_q <= zero_d;
            busy_q <= busy_d;
            done_q <= done_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end
    assign result = result_q;
    assign zero = zero_q;
    assign busy = busy_q;
    assign done = done_q;
    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized scoreboard bench for seq_alu against an arithmetic reference model
module tb_seq_alu;
    logic clk = 0, rst = 1, start = 0;
    logic [3:0] op = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0] sh = '0;
    logic [31:0] result, hi, lo;
    logic zero, busy, done;
    seq_alu dut (
        .clk(clk), .rst(rst), .start(start), .ALUctrl(op), .input1(a), .input2(b),
        .shiftAmount(sh), .result(result), .zero(zero), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] res, hi, lo;
        int cyc;
        bit md;
    } exp_t;
    exp_t sbq[$];
    int checks = 0, errors = 0, cyc = 0, brun = 0;
    logic [31:0] mhi = '0, mlo = '0, cur_res = '0, cur_hi = '0, cur_lo = '0;
    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return 32'h8000_0000;
            2: return '1;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction
    task automatic reset_chk();
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
    endtask
    // reference model: mul/div from 64-bit integer arithmetic, HI/LO kept as plain variables
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
        exp_t e;
        longint sx, sy;
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_idle", busy, 0);
        sx = $signed(x);
        sy = $signed(y);
        e.res = '0;
        e.md = o inside {4'd10, 4'd11, 4'd12, 4'd13};
        case (o)
            4'd0: e.res = x & y;
            4'd1: e.res = x | y;
            4'd2: e.res = x + y;
            4'd3: e.res = x ^ y;
            4'd4: e.res = y << s;
            4'd5: e.res = y >> s;
            4'd8: e.res = $signed(y) >>> s;
            4'd6: e.res = x - y;
            4'd7: e.res = {31'b0, sx < sy};
            4'd9: e.res = {31'b0, x < y};
            4'd10: {mhi, mlo} = {32'b0, x} * {32'b0, y};
            4'd11: {mhi, mlo} = sx * sy;
            4'd12, 4'd13: begin
                if (y == 0) begin
                    mlo = '1;
                    mhi = x;
                end else if (o == 4'd12) begin
                    mlo = x / y;
                    mhi = x % y;
                end else begin
                    mlo = 32'(sx / sy);
                    mhi = 32'(sx % sy);
                end
            end
            4'd14: e.res = mhi;
            default: e.res = mlo;
        endcase
        if (e.md) e.res = mlo;
        e.hi = mhi;
        e.lo = mlo;
        e.cyc = cyc + (e.md ? 34 : 1);
        op = o;
        a = x;
        b = y;
        sh = s;
        start = 1;
        sbq.push_back(e);
        @(negedge clk);
        start = 0;
    endtask
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            sbq.delete();
            cur_res = '0;
            cur_hi = '0;
            cur_lo = '0;
            brun = 0;
        end else begin
            if (busy) brun++;
            if (done) begin
                if (sbq.size() == 0) chk("spurious_done", done, 0);
                else begin
                    e = sbq.pop_front();
                    chk("result", result, e.res);
                    chk("zero", zero, e.res == 0);
                    chk("hi", hi, e.hi);
                    chk("lo", lo, e.lo);
                    chk("latency", cyc, e.cyc);
                    chk("busy_cycles", brun, e.md ? 33 : 0);
                    cur_res = e.res;
                    cur_hi = e.hi;
                    cur_lo = e.lo;
                end
                brun = 0;
            end else begin
                chk("hold_result", result, cur_res);
                chk("hold_hi", hi, cur_hi);
                chk("hold_lo", lo, cur_lo);
                if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
                    chk("done_timeout", cyc, sbq[0].cyc);
                    void'(sbq.pop_front());
                end
            end
        end
    end
    initial begin
        int n;
        @(negedge clk);
        reset_chk();
        @(negedge clk);
        rst = 0;
        issue(4'd2, 3, 9, 0);
        issue(4'd0, 4, 8, 0);
        issue(4'd6, 5, 5, 0);
        issue(4'd7, 32'hFFFF_FFFF, 2, 0);
        issue(4'd9, 32'hFFFF_FFFF, 2, 0);
        issue(4'd4, 0, 12, 2);
        issue(4'd5, 0, 32'h8000_0000, 4);
        issue(4'd8, 0, 32'h8000_0000, 4);
        issue(4'd11, 32'hFFFF_FFFD, 7, 0);
        repeat (5) @(negedge clk);
        op = 4'd2;
        a = 1;
        b = 1;
        start = 1;
        @(negedge clk);
        start = 0;
        issue(4'd14, 0, 0, 0);
        issue(4'd15, 0, 0, 0);
        issue(4'd13, 32'hFFFF_FFEF, 5, 0);
        issue(4'd14, 0, 0, 0);
        issue(4'd12, 7, 0, 0);
        issue(4'd14, 0, 0, 0);
        issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(4'd14, 0, 0, 0);
        issue(4'd15, 0, 0, 0);
        for (int i = 0; i < 40; i++)
            issue(4'($urandom_range(0, 15)), pick(), pick(), 5'($urandom_range(0, 31)));
        issue(4'd11, 32'hFFFF_FFFD, 7, 0);
        issue(4'd10, 32'hFFFF_FFFF, 2, 0);
        repeat (9) @(negedge clk);
        #2 rst = 1;
        #1 reset_chk();
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        issue(4'd10, 32'hFFFF_FFFF, 2, 0);
        n = 0;
        while (sbq.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sbq.size(), 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the MIPS datapath, succeeding the single-cycle combinational ALU. It keeps the single-cycle logic, arithmetic and shift operations and adds iterative signed and unsigned multiply and divide, which write a HI/LO register pair. A start/busy/done handshake lets the control unit stall the pipeline while a multiply or divide runs. The block sits in the EX stage, and its outputs are registered.

## Interface
- `WIDTH`, default 32: operand, result, HI and LO width. Must be an even number ≥ 4.
- `SHW`, default 5: shift-amount width. Must equal `$clog2(WIDTH)`.

Ports:
- `clk`  in  1: the single clock; rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request to execute `ALUctrl` on the current operands. Sampled only when `busy` = 0.
- `ALUctrl`  in  4: operation code.
- `input1`  in  WIDTH: operand A, or the dividend / multiplicand.
- `input2`  in  WIDTH: operand B, or the divisor / multiplier, or the value to shift.
- `shiftAmount`  in  SHW: shift distance.
- `result`  out  WIDTH: registered result.
- `zero`  out  1: registered, equals (`result` == 0).
- `busy`  out  1: a multiply or divide is in progress.
- `done`  out  1: one-cycle pulse marking `result` (and HI/LO, for mul/div) as updated.
- `hi`, `lo`  out  WIDTH each: the HI/LO register pair.

## Operation
Operation codes:
- 0000 AND, 0001 OR, 0010 ADD, 0011 XOR.
- 0100 SLL (`input2` << `shiftAmount`), 0101 SRL, 1000 SRA (arithmetic right shift of `input2`).
- 0110 SUB (`input1` − `input2`).
- 0111 SLT (signed), 1001 SLTU. Both produce 1 or 0, zero-extended.
- 1010 MULTU, 1011 MULT: {hi,lo} = full 2·WIDTH-bit product.
- 1100 DIVU, 1101 DIV: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
- 1110 MFHI, 1111 MFLO: result = hi / lo.

Arithmetic rules:
- ADD and SUB wrap modulo 2^WIDTH. There is no overflow trap.

State machine (IDLE, RUN, FIX):
- IDLE with `start` and a single-cycle op: register `result`/`zero`, pulse `done`, stay in IDLE.
- IDLE with `start` and a mul/div op: latch operand magnitudes and the result sign(s), load the iteration counter with WIDTH, set `busy`, go to RUN.
  - MULTU and DIVU treat operands as unsigned.
  - MULT and DIV take absolute values.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. When the counter reaches 0, go to FIX.
- FIX: apply sign correction, write `hi`/`lo`, set `result` = new lo and update `zero`, pulse `done`, clear `busy`, return to IDLE.

Boundary conditions:
- Divide by zero (DIVU or DIV with `input2` = 0): lo = all ones, hi = `input1`. Normal latency, no flag.
- DIV of the most-negative value by −1: lo = most-negative value, hi = 0.
- `start` while `busy` = 1 is ignored, whatever the opcode.
- `result`, `zero`, `hi` and `lo` hold their values between updates.
- Single-cycle ops never modify `hi`/`lo`.
- MFHI/MFLO issued on the cycle after a `done` return the new hi/lo.
- `rst` at any time, including mid-RUN, resets immediately and asynchronously:
  - state goes to IDLE;
  - `result`, `hi`, `lo`, `busy`, `done` go to 0, and `zero` goes to 1;
  - the partial mul/div is discarded.

## Timing
- Reset values: `result` = 0, `zero` = 1, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0.
- Single-cycle ops: `start` sampled at edge k gives `result`/`zero`/`done` valid after edge k. Latency is 1, and back-to-back starts are accepted every cycle.
- Mul/div: `start` sampled at edge k.
  - `busy` = 1 after edges k through k+WIDTH.
  - `done` = 1, `busy` = 0 and hi/lo/result are valid after edge k+WIDTH+1, i.e. 33 cycles for WIDTH = 32.
  - A new `start` is accepted in the same cycle that `done` is high.
- `done` is high for exactly one cycle per accepted operation.

## Test plan
1. ADD 3+9 → result 12, zero 0, done one cycle after start. AND 4&8 → result 0, zero 1.
2. SUB 5−5 → 0 with zero 1. SLT 0xFFFFFFFF vs 2 → 1. SLTU with the same operands → 0.
3. SLL 12 by 2 → 48. SRL 0x80000000 by 4 → 0x08000000. SRA 0x80000000 by 4 → 0xF8000000.
4. MULT −3 × 7 → hi 0xFFFFFFFF, lo 0xFFFFFFEB, result 0xFFFFFFEB.
   - `busy` high for exactly 33 cycles and `done` in cycle 33.
   - A `start` with ADD pulsed mid-run is ignored; result and hi/lo are unchanged by it.
5. DIV −17 / 5 → lo 0xFFFFFFFD, hi 0xFFFFFFFE. DIVU 7 / 0 → lo 0xFFFFFFFF, hi 7. DIV 0x80000000 / −1 → lo 0x80000000, hi 0. Each is followed by MFHI, which must return the new hi one cycle after `done`.
6. Assert `rst` at cycle 10 of MULTU 0xFFFFFFFF × 2 → `busy`/`hi`/`lo` go to 0 without a clock edge, and no `done` is produced. After release, the same MULTU → hi 1, lo 0xFFFFFFFE.
